// File: rtl/predictor_pkg.sv
// Shared widths, the scheduler state encoding and the buffered update record
// for the tournament predictor update path.
package predictor_pkg;

  localparam int IP_W                = 16;
  localparam int FIFO_DEPTH_DEF      = 4;
  localparam int LOCAL_HIST_LEN_DEF  = 6;
  localparam int LOCAL_HIST_IDX_DEF  = 10;
  localparam int LOCAL_BIT_IDX_DEF   = 5;
  localparam int GLOBAL_HIST_LEN_DEF = 12;
  localparam int GLOBAL_BIT_IDX_DEF  = 12;
  localparam int META_BIT_IDX_DEF    = 10;

  // Value the counter tables load when ctr_clear qualifies a write
  localparam logic [1:0] CTR_INIT = 2'b01;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_IDLE  = 2'd1,
    ST_READ  = 2'd2,
    ST_WRITE = 2'd3
  } sched_state_e;

  typedef struct packed {
    logic [IP_W-1:0] ip;
    logic            taken;
    logic            pl;
    logic            pg;
  } upd_rec_t;

endpackage

// File: rtl/update_fifo.sv
// Small synchronous FIFO of resolved-branch records; the head is visible
// combinationally from storage so a pop can latch it in the same cycle.
module update_fifo
  import predictor_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH_DEF
) (
  input  logic     i_clk,
  input  logic     i_rst_n,
  input  logic     i_clr,
  input  logic     i_push,
  input  logic     i_pop,
  input  upd_rec_t i_din,
  output upd_rec_t o_dout,
  output logic     o_full,
  output logic     o_empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  upd_rec_t      r_mem [DEPTH];
  logic          w_push_ok;
  logic          w_pop_ok;

  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop && !o_empty;
  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_dout    = r_mem[r_rd_ptr];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + {{AW{1'b0}}, w_push_ok} - {{AW{1'b0}}, w_pop_ok};
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_din;
  end

endmodule

// File: rtl/predictor_update_scheduler.sv
// Serialises predictor table writes: a clear sweep after reset/flush, then
// one read-modify-write per buffered resolved branch.
//   state | meaning
//   CLEAR | sweep s over every index, forcing counters to CTR_INIT, LHT to 0
//   IDLE  | waiting for a buffered record
//   READ  | pop record, issue LHT read for its history
//   WRITE | update local/global/meta counters, LHT entry and ghr
module predictor_update_scheduler
  import predictor_pkg::*;
#(
  parameter int FIFO_DEPTH      = FIFO_DEPTH_DEF,
  parameter int LOCAL_HIST_LEN  = LOCAL_HIST_LEN_DEF,
  parameter int LOCAL_HIST_IDX  = LOCAL_HIST_IDX_DEF,
  parameter int LOCAL_BIT_IDX   = LOCAL_BIT_IDX_DEF,
  parameter int GLOBAL_HIST_LEN = GLOBAL_HIST_LEN_DEF,
  parameter int GLOBAL_BIT_IDX  = GLOBAL_BIT_IDX_DEF,
  parameter int META_BIT_IDX    = META_BIT_IDX_DEF
) (
  input  logic                                    CLOCK_50,
  input  logic                                    rst_n,
  input  logic                                    flush,
  input  logic                                    upd_valid,
  output logic                                    upd_ready,
  input  logic [IP_W-1:0]                         upd_ip,
  input  logic                                    upd_taken,
  input  logic                                    upd_pl,
  input  logic                                    upd_pg,
  output logic [LOCAL_HIST_IDX-1:0]               lht_rd_addr,
  input  logic [LOCAL_HIST_LEN-1:0]               lht_rd_data,
  output logic                                    lht_we,
  output logic [LOCAL_HIST_IDX-1:0]               lht_wr_addr,
  output logic [LOCAL_HIST_LEN-1:0]               lht_wr_data,
  output logic [2:0]                              ctr_we,
  output logic [2:0]                              ctr_inc,
  output logic                                    ctr_clear,
  output logic [LOCAL_BIT_IDX+LOCAL_HIST_LEN-1:0] local_idx,
  output logic [GLOBAL_BIT_IDX-1:0]               global_idx,
  output logic [META_BIT_IDX-1:0]                 meta_idx,
  output logic [GLOBAL_HIST_LEN-1:0]              ghr,
  output logic                                    busy
);

  localparam int LIDX_W = LOCAL_BIT_IDX + LOCAL_HIST_LEN;

  sched_state_e                r_state;
  sched_state_e                w_next;
  logic [GLOBAL_BIT_IDX-1:0]   r_s;
  logic                        r_run;
  logic [GLOBAL_HIST_LEN-1:0]  r_ghr;
  upd_rec_t                    r_rec;
  upd_rec_t                    w_head;
  upd_rec_t                    w_din;
  logic                        w_full;
  logic                        w_empty;
  logic                        w_push;
  logic                        w_pop;
  logic                        w_unused_ip;

  assign w_din       = '{ip: upd_ip, taken: upd_taken, pl: upd_pl, pg: upd_pg};
  assign upd_ready   = !w_full && (r_state != ST_CLEAR) && !flush;
  assign w_push      = upd_valid && upd_ready;
  assign w_pop       = (r_state == ST_READ) && !flush;
  assign busy        = (r_state == ST_CLEAR);
  assign ghr         = r_ghr;
  assign w_unused_ip = ^r_rec.ip[IP_W-1:GLOBAL_BIT_IDX];

  update_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .i_clk   (CLOCK_50),
    .i_rst_n (rst_n),
    .i_clr   (flush),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   (w_din),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_CLEAR: if (r_run && (&r_s)) w_next = ST_IDLE;
      ST_IDLE:  if (!w_empty) w_next = ST_READ;
      ST_READ:  w_next = ST_WRITE;
      ST_WRITE: w_next = w_empty ? ST_IDLE : ST_READ;
      default:  w_next = ST_CLEAR;
    endcase
    if (flush) w_next = ST_CLEAR;
  end

  // r_run holds off the sweep while reset is asserted so no write strobes leak out
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_CLEAR;
      r_s     <= '0;
      r_run   <= 1'b0;
      r_ghr   <= '0;
      r_rec   <= '0;
    end else begin
      r_run   <= 1'b1;
      r_state <= w_next;
      if (flush) begin
        r_s   <= '0;
        r_ghr <= '0;
      end else begin
        if (r_state == ST_CLEAR && r_run) r_s <= r_s + 1'b1;
        if (r_state == ST_WRITE) r_ghr <= {r_ghr[GLOBAL_HIST_LEN-2:0], r_rec.taken};
      end
      if (w_pop) r_rec <= w_head;
    end
  end

  always_comb begin
    lht_rd_addr = '0;
    lht_we      = 1'b0;
    lht_wr_addr = '0;
    lht_wr_data = '0;
    ctr_we      = 3'b000;
    ctr_inc     = 3'b000;
    ctr_clear   = 1'b0;
    local_idx   = '0;
    global_idx  = '0;
    meta_idx    = '0;
    case (r_state)
      ST_CLEAR: begin
        if (r_run) begin
          ctr_we     = 3'b111;
          ctr_clear  = 1'b1;
          global_idx = r_s;
          local_idx  = r_s[LIDX_W-1:0];
          meta_idx   = r_s[META_BIT_IDX-1:0];
          if (r_s[GLOBAL_BIT_IDX-1:LOCAL_HIST_IDX] == '0) begin
            lht_we      = 1'b1;
            lht_wr_addr = r_s[LOCAL_HIST_IDX-1:0];
          end
        end
      end
      ST_READ: lht_rd_addr = w_head.ip[LOCAL_HIST_IDX-1:0];
      ST_WRITE: begin
        local_idx   = {r_rec.ip[LOCAL_BIT_IDX-1:0], lht_rd_data};
        global_idx  = r_rec.ip[GLOBAL_BIT_IDX-1:0] ^ r_ghr;
        meta_idx    = r_rec.ip[META_BIT_IDX-1:0];
        ctr_we      = {r_rec.pl != r_rec.pg, 2'b11};
        ctr_inc     = {r_rec.pg == r_rec.taken, r_rec.taken, r_rec.taken};
        lht_we      = 1'b1;
        lht_wr_addr = r_rec.ip[LOCAL_HIST_IDX-1:0];
        lht_wr_data = {lht_rd_data[LOCAL_HIST_LEN-2:0], r_rec.taken};
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_predictor_update_scheduler.sv
// Directed bench for predictor_update_scheduler with a behavioural LHT RAM,
// a hand-computed vector table and an expected-write queue.
module tb_predictor_update_scheduler;

  logic        CLOCK_50;
  logic        rst_n;
  logic        flush;
  logic        upd_valid;
  logic        upd_ready;
  logic [15:0] upd_ip;
  logic        upd_taken;
  logic        upd_pl;
  logic        upd_pg;
  logic [9:0]  lht_rd_addr;
  logic [5:0]  lht_rd_data;
  logic        lht_we;
  logic [9:0]  lht_wr_addr;
  logic [5:0]  lht_wr_data;
  logic [2:0]  ctr_we;
  logic [2:0]  ctr_inc;
  logic        ctr_clear;
  logic [10:0] local_idx;
  logic [11:0] global_idx;
  logic [9:0]  meta_idx;
  logic [11:0] ghr;
  logic        busy;

  predictor_update_scheduler dut (
    .CLOCK_50    (CLOCK_50),
    .rst_n       (rst_n),
    .flush       (flush),
    .upd_valid   (upd_valid),
    .upd_ready   (upd_ready),
    .upd_ip      (upd_ip),
    .upd_taken   (upd_taken),
    .upd_pl      (upd_pl),
    .upd_pg      (upd_pg),
    .lht_rd_addr (lht_rd_addr),
    .lht_rd_data (lht_rd_data),
    .lht_we      (lht_we),
    .lht_wr_addr (lht_wr_addr),
    .lht_wr_data (lht_wr_data),
    .ctr_we      (ctr_we),
    .ctr_inc     (ctr_inc),
    .ctr_clear   (ctr_clear),
    .local_idx   (local_idx),
    .global_idx  (global_idx),
    .meta_idx    (meta_idx),
    .ghr         (ghr),
    .busy        (busy)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int unexp  = 0;

  always @(posedge CLOCK_50) cyc = cyc + 1;

  // Local history table RAM, 1-cycle synchronous read
  logic [5:0] lht_mem [1024];
  always @(posedge CLOCK_50) begin
    if (lht_we) lht_mem[lht_wr_addr] <= lht_wr_data;
    lht_rd_data <= lht_mem[lht_rd_addr];
  end

  typedef struct {
    logic [10:0] lidx;
    logic [11:0] gidx;
    logic [9:0]  midx;
    logic [2:0]  we;
    logic [2:0]  inc;
    logic [5:0]  wd;
    logic [9:0]  wa;
    logic [11:0] ghr_before;
  } exp_t;

  typedef struct {
    logic [15:0] ip;
    logic        t;
    logic        pl;
    logic        pg;
    logic [10:0] lidx;
    logic [11:0] gidx;
    logic [9:0]  midx;
    logic [2:0]  we;
    logic [2:0]  inc;
    logic [5:0]  wd;
    logic [11:0] ghr_after;
  } vec_t;

  exp_t       exp_q [$];
  int         wr_cyc [$];
  logic [5:0] m_lht [1024];
  logic [11:0] m_ghr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic model_reset();
    m_ghr = '0;
    for (int i = 0; i < 1024; i++) m_lht[i] = '0;
  endtask

  task automatic model_apply(input logic [15:0] ip, input logic t, input logic pl,
                             input logic pg, output exp_t e);
    logic [5:0] h;
    h = m_lht[ip[9:0]];
    e.lidx       = {ip[4:0], h};
    e.gidx       = ip[11:0] ^ m_ghr;
    e.midx       = ip[9:0];
    e.we         = {pl != pg, 2'b11};
    e.inc        = {pg == t, t, t};
    e.wd         = {h[4:0], t};
    e.wa         = ip[9:0];
    e.ghr_before = m_ghr;
    m_lht[ip[9:0]] = {h[4:0], t};
    m_ghr = {m_ghr[10:0], t};
  endtask

  always @(negedge CLOCK_50) begin
    if (rst_n && ctr_we != 3'b000 && !ctr_clear) begin
      if (exp_q.size() == 0) begin
        unexp++;
        chk("unexpected_write", {29'd0, ctr_we}, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        wr_cyc.push_back(cyc);
        chk("wr_local_idx",   {21'd0, local_idx},   {21'd0, e.lidx});
        chk("wr_global_idx",  {20'd0, global_idx},  {20'd0, e.gidx});
        chk("wr_meta_idx",    {22'd0, meta_idx},    {22'd0, e.midx});
        chk("wr_ctr_we",      {29'd0, ctr_we},      {29'd0, e.we});
        chk("wr_ctr_inc",     {29'd0, ctr_inc},     {29'd0, e.inc});
        chk("wr_lht_we",      {31'd0, lht_we},      32'd1);
        chk("wr_lht_wr_addr", {22'd0, lht_wr_addr}, {22'd0, e.wa});
        chk("wr_lht_wr_data", {26'd0, lht_wr_data}, {26'd0, e.wd});
        chk("wr_ghr_before",  {20'd0, ghr},         {20'd0, e.ghr_before});
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [15:0] ip, input logic t, input logic pl,
                      input logic pg, output int acc_cyc);
    bit done;
    done = 0;
    acc_cyc = -1;
    upd_ip = ip; upd_taken = t; upd_pl = pl; upd_pg = pg; upd_valid = 1'b1;
    for (int c = 0; c < 100 && !done; c++) begin
      #1;
      if (upd_ready) begin
        @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        acc_cyc = cyc;
        done = 1;
      end else begin
        @(negedge CLOCK_50);
      end
    end
    if (!done) chk("send_timeout", 32'd1, 32'd0);
  endtask

  task automatic wait_drain(input string nm);
    for (int c = 0; c < 60; c++) begin
      if (exp_q.size() == 0) break;
      @(negedge CLOCK_50);
    end
    if (exp_q.size() != 0) begin
      chk({nm, "_drain_timeout"}, exp_q.size(), 32'd0);
      exp_q.delete();
    end
  endtask

  task automatic sweep_check(input string nm);
    int n, nl, bad;
    n = 0; nl = 0; bad = 0;
    for (int c = 0; c < 5000; c++) begin
      if (!busy) break;
      if (ctr_we == 3'b111 && ctr_clear) begin
        if (global_idx != n[11:0]) bad++;
        if (meta_idx != n[9:0] || local_idx != n[10:0]) bad++;
        if (lht_we) begin
          nl++;
          if (n >= 1024 || lht_wr_addr != n[9:0] || lht_wr_data != 6'd0) bad++;
        end else if (n < 1024) bad++;
        n++;
      end else if (ctr_we != 3'b000 || lht_we || ctr_clear) bad++;
      @(negedge CLOCK_50);
    end
    chk({nm, "_clear_cycles"}, n, 32'd4096);
    chk({nm, "_lht_clears"}, nl, 32'd1024);
    chk({nm, "_sweep_pattern"}, bad, 32'd0);
    chk({nm, "_busy_fall"}, {31'd0, busy}, 32'd0);
    chk({nm, "_ready_rise"}, {31'd0, upd_ready}, 32'd1);
    chk({nm, "_ghr_zero"}, {20'd0, ghr}, 32'd0);
  endtask

  vec_t tv [6];
  logic [15:0] b_ip [6];
  logic [2:0]  b_tpp [6];

  initial begin
    int acc;
    int acc_b [6];
    int wbase;
    exp_t e;

    tv[0] = '{16'h0123, 1'b1, 1'b0, 1'b1, 11'h0C0, 12'h123, 10'h123, 3'b111, 3'b111, 6'h01, 12'h001};
    tv[1] = '{16'h0456, 1'b0, 1'b1, 1'b1, 11'h580, 12'h457, 10'h056, 3'b011, 3'b000, 6'h00, 12'h002};
    tv[2] = '{16'h0123, 1'b1, 1'b1, 1'b0, 11'h0C1, 12'h121, 10'h123, 3'b111, 3'b011, 6'h03, 12'h005};
    tv[3] = '{16'hFFFF, 1'b1, 1'b0, 1'b1, 11'h7C0, 12'hFFA, 10'h3FF, 3'b111, 3'b111, 6'h01, 12'h00B};
    tv[4] = '{16'h0523, 1'b0, 1'b0, 1'b1, 11'h0C3, 12'h528, 10'h123, 3'b111, 3'b000, 6'h06, 12'h016};
    tv[5] = '{16'h0123, 1'b1, 1'b1, 1'b0, 11'h0C6, 12'h135, 10'h123, 3'b111, 3'b011, 6'h0D, 12'h02D};

    b_ip[0] = 16'h0AB1; b_tpp[0] = 3'b101;
    b_ip[1] = 16'h1234; b_tpp[1] = 3'b010;
    b_ip[2] = 16'h0AB1; b_tpp[2] = 3'b111;
    b_ip[3] = 16'h7F00; b_tpp[3] = 3'b001;
    b_ip[4] = 16'h0123; b_tpp[4] = 3'b100;
    b_ip[5] = 16'hC3C3; b_tpp[5] = 3'b110;

    for (int i = 0; i < 1024; i++) lht_mem[i] = 6'h2A;
    lht_rd_data = '0;
    rst_n = 1'b0; flush = 1'b0; upd_valid = 1'b0;
    upd_ip = '0; upd_taken = 1'b0; upd_pl = 1'b0; upd_pg = 1'b0;
    model_reset();

    repeat (3) @(negedge CLOCK_50);
    chk("rst_busy",        {31'd0, busy},        32'd1);
    chk("rst_upd_ready",   {31'd0, upd_ready},   32'd0);
    chk("rst_ctr_we",      {29'd0, ctr_we},      32'd0);
    chk("rst_ctr_clear",   {31'd0, ctr_clear},   32'd0);
    chk("rst_lht_we",      {31'd0, lht_we},      32'd0);
    chk("rst_ghr",         {20'd0, ghr},         32'd0);
    chk("rst_global_idx",  {20'd0, global_idx},  32'd0);
    chk("rst_local_idx",   {21'd0, local_idx},   32'd0);
    chk("rst_lht_rd_addr", {22'd0, lht_rd_addr}, 32'd0);

    rst_n = 1'b1;
    #1;
    sweep_check("reset");

    for (int i = 0; i < 6; i++) begin
      model_apply(tv[i].ip, tv[i].t, tv[i].pl, tv[i].pg, e);
      e.lidx = tv[i].lidx; e.gidx = tv[i].gidx; e.midx = tv[i].midx;
      e.we = tv[i].we; e.inc = tv[i].inc; e.wd = tv[i].wd; e.wa = tv[i].ip[9:0];
      e.ghr_before = (i == 0) ? 12'h000 : tv[i-1].ghr_after;
      exp_q.push_back(e);
      send(tv[i].ip, tv[i].t, tv[i].pl, tv[i].pg, acc);
      upd_valid = 1'b0;
      wait_drain("vec");
      if (wr_cyc.size() > 0) chk("vec_latency", wr_cyc[wr_cyc.size()-1] - acc, 32'd2);
      @(posedge CLOCK_50);
      #1;
      chk("vec_ghr_after", {20'd0, ghr}, {20'd0, tv[i].ghr_after});
      @(negedge CLOCK_50);
    end

    wbase = wr_cyc.size();
    for (int i = 0; i < 6; i++) begin
      model_apply(b_ip[i], b_tpp[i][2], b_tpp[i][1], b_tpp[i][0], e);
      exp_q.push_back(e);
      send(b_ip[i], b_tpp[i][2], b_tpp[i][1], b_tpp[i][0], acc_b[i]);
    end
    #1;
    chk("burst_ready_full", {31'd0, upd_ready}, 32'd0);
    upd_valid = 1'b0;
    for (int i = 1; i < 6; i++) chk("burst_accept_gap", acc_b[i] - acc_b[i-1], 32'd1);
    wait_drain("burst");
    @(posedge CLOCK_50);
    #1;
    chk("burst_writes", wr_cyc.size() - wbase, 32'd6);
    if (wr_cyc.size() - wbase == 6)
      for (int i = 1; i < 6; i++) chk("burst_write_gap", wr_cyc[wbase+i] - wr_cyc[wbase+i-1], 32'd2);
    chk("burst_ghr", {20'd0, ghr}, {20'd0, m_ghr});
    @(negedge CLOCK_50);

    // Four records back-to-back: the first reaches WRITE, three are pending at flush
    model_apply(16'h0321, 1'b1, 1'b0, 1'b1, e);
    exp_q.push_back(e);
    send(16'h0321, 1'b1, 1'b0, 1'b1, acc);
    send(16'h0654, 1'b1, 1'b1, 1'b0, acc);
    send(16'h0987, 1'b0, 1'b0, 1'b1, acc);
    send(16'h0ABC, 1'b1, 1'b1, 1'b1, acc);
    upd_valid = 1'b0;
    flush = 1'b1;
    #1;
    chk("flush_ready_low", {31'd0, upd_ready}, 32'd0);
    chk("flush_pre_ghr_nonzero", {31'd0, ghr == 12'h000}, 32'd0);
    @(negedge CLOCK_50);
    flush = 1'b0;
    chk("flush_busy", {31'd0, busy}, 32'd1);
    chk("flush_ghr", {20'd0, ghr}, 32'd0);
    model_reset();
    sweep_check("flush");
    repeat (10) @(negedge CLOCK_50);
    chk("flush_no_pending_applied", unexp, 32'd0);
    chk("flush_exp_empty", exp_q.size(), 32'd0);

    model_apply(16'h0ABC, 1'b1, 1'b0, 1'b1, e);
    exp_q.push_back(e);
    send(16'h0ABC, 1'b1, 1'b0, 1'b1, acc);
    upd_valid = 1'b0;
    wait_drain("post_flush");

    // Reset in the middle of a WRITE cycle
    @(negedge CLOCK_50);
    model_apply(16'h0155, 1'b1, 1'b1, 1'b0, e);
    exp_q.push_back(e);
    send(16'h0155, 1'b1, 1'b1, 1'b0, acc);
    upd_valid = 1'b0;
    begin
      bit seen;
      seen = 0;
      for (int c = 0; c < 20 && !seen; c++) begin
        @(negedge CLOCK_50);
        #1;
        if (ctr_we != 3'b000 && !ctr_clear) seen = 1;
      end
      chk("midwrite_seen", {31'd0, seen}, 32'd1);
    end
    rst_n = 1'b0;
    #1;
    chk("midrst_ctr_we",    {29'd0, ctr_we},    32'd0);
    chk("midrst_lht_we",    {31'd0, lht_we},    32'd0);
    chk("midrst_ctr_clear", {31'd0, ctr_clear}, 32'd0);
    chk("midrst_busy",      {31'd0, busy},      32'd1);
    chk("midrst_ready",     {31'd0, upd_ready}, 32'd0);
    chk("midrst_ghr",       {20'd0, ghr},       32'd0);
    chk("midrst_local_idx", {21'd0, local_idx}, 32'd0);
    chk("midrst_gidx",      {20'd0, global_idx}, 32'd0);
    exp_q.delete();
    model_reset();
    repeat (2) @(negedge CLOCK_50);
    rst_n = 1'b1;
    #1;
    sweep_check("rst2");

    @(negedge CLOCK_50);
    model_apply(16'h0155, 1'b0, 1'b0, 1'b0, e);
    exp_q.push_back(e);
    send(16'h0155, 1'b0, 1'b0, 1'b0, acc);
    upd_valid = 1'b0;
    wait_drain("post_rst");
    repeat (4) @(negedge CLOCK_50);
    chk("final_unexpected", unexp, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/predictor_update_scheduler.md
# predictor_update_scheduler

Sequences all writes into the tournament branch predictor's tables: local history table, local/global/meta 2-bit saturating counters, and the global history register. Resolved-branch records from execute are buffered in a small FIFO and applied one at a time through a read-modify-write sequence, so the predictor tables need only one write port each. After reset or a flush, a clear sweep initialises every table entry before updates are accepted.

## Interface
- `FIFO_DEPTH`, 4: resolved-branch record buffer depth (power of two).
- `LOCAL_HIST_LEN`, 6: bits per local history entry.
- `LOCAL_HIST_IDX`, 10: local history table index width.
- `LOCAL_BIT_IDX`, 5: IP bits concatenated with local history for the local counter index.
- `GLOBAL_HIST_LEN`, 12: global history register width (must equal `GLOBAL_BIT_IDX`).
- `GLOBAL_BIT_IDX`, 12: global counter index width; also sets the sweep length.
- `META_BIT_IDX`, 10: meta counter index width.

Ports:
- `CLOCK_50` in 1: sole clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `flush` in 1: abort pending updates and restart the clear sweep.
- `upd_valid` in 1 / `upd_ready` out 1: resolved-branch handshake.
- `upd_ip` in 16: IP of the resolved branch.
- `upd_taken` in 1: actual branch direction.
- `upd_pl`, `upd_pg` in 1: local and global predictions made at fetch for this branch.
- `lht_rd_addr` out `LOCAL_HIST_IDX`; `lht_rd_data` in `LOCAL_HIST_LEN`: synchronous read, 1-cycle latency.
- `lht_we` out 1, `lht_wr_addr` out `LOCAL_HIST_IDX`, `lht_wr_data` out `LOCAL_HIST_LEN`: local history table write port.
- `ctr_we` out 3: counter write enables; bit 0 local, bit 1 global, bit 2 meta.
- `ctr_inc` out 3: per-counter direction; 1 means increment, 0 means decrement.
- `ctr_clear` out 1: qualified by `ctr_we`; forces the addressed counters to weakly-not-taken (2'b01).
- `local_idx` out `LOCAL_BIT_IDX+LOCAL_HIST_LEN`, `global_idx` out `GLOBAL_BIT_IDX`, `meta_idx` out `META_BIT_IDX`: counter addresses.
- `ghr` out `GLOBAL_HIST_LEN`: global history register, consumed by fetch-side prediction.
- `busy` out 1: high while the clear sweep is running.

## Operation
- FSM states: CLEAR, IDLE, READ, WRITE.
- **CLEAR:** 12-bit sweep counter `s` runs 0 to 2^GLOBAL_BIT_IDX-1, one index per cycle.
  - Every cycle: `ctr_we`=3'b111, `ctr_clear`=1, `global_idx`=s.
  - `local_idx` = s truncated to `LOCAL_BIT_IDX+LOCAL_HIST_LEN` bits; `meta_idx` = s truncated to `META_BIT_IDX` bits.
  - `lht_we`=1 with `lht_wr_data`=0 only while s < 2^LOCAL_HIST_IDX.
  - After s = max, go to IDLE.
- **IDLE:** FIFO non-empty → READ.
- **READ:** pop the FIFO head into a working register and drive `lht_rd_addr` = ip[LOCAL_HIST_IDX-1:0]. Go to WRITE.
- **WRITE:** with h = `lht_rd_data`:
  - Local counter: `local_idx` = {ip[LOCAL_BIT_IDX-1:0], h}, `ctr_we[0]`=1, `ctr_inc[0]`=taken.
  - Global counter: `global_idx` = ip[GLOBAL_BIT_IDX-1:0] ^ `ghr`, using `ghr` before this update; `ctr_we[1]`=1, `ctr_inc[1]`=taken.
  - Meta counter: `meta_idx` = ip[META_BIT_IDX-1:0], `ctr_we[2]` = (pl != pg), `ctr_inc[2]` = (pg == taken).
  - Local history: `lht_we`=1, `lht_wr_addr` = READ address, `lht_wr_data` = {h[LOCAL_HIST_LEN-2:0], taken}.
  - Global history: `ghr` <= {ghr[GLOBAL_HIST_LEN-2:0], taken}.
  - Next state: READ if the FIFO is non-empty, else IDLE.
- **Handshake:**
  - `upd_ready` = !full && state != CLEAR && !flush.
  - Push on `upd_valid && upd_ready`.
  - A push and a pop in the same cycle are both honoured; `upd_ready` is still computed from the current `full`, with no bypass.
- **flush:** takes priority over everything.
  - Next state is CLEAR with s=0, FIFO emptied, `ghr`=0.
  - An in-flight WRITE in the flush cycle still drives its writes; its `ghr` shift is discarded.
- Outside CLEAR/WRITE, all `*_we` are 0 and `ctr_clear`=0.

## Timing
- Reset values:
  - State CLEAR, s=0, FIFO empty, `ghr`=0.
  - `busy`=1, `upd_ready`=0, `lht_we`=0, `ctr_we`=0, `ctr_clear`=0.
  - All address/data outputs 0.
- Sweep:
  - The first clear write occurs in the first cycle after `rst_n` rises.
  - The sweep lasts 4096 cycles at default parameters.
  - `busy` falls, and `upd_ready` rises, the cycle after s=4095.
- Update latency: record accepted at edge N → READ at N+1 at the earliest → table writes and `ghr` update at edge N+3.
- Throughput: one record per 2 cycles. With FIFO_DEPTH=4, sustained back-to-back input fills the FIFO and deasserts `upd_ready`.
- All outputs are registered or decoded from registered state only; no combinational path from `upd_*` to any output other than none.

## Structure
- Package `predictor_pkg` contains:
  - The width parameters' default constants.
  - `CTR_INIT` = 2'b01.
  - The FSM state enum.
  - The `upd_rec_t` struct {ip, taken, pl, pg}.
- Sub-module `update_fifo`: synchronous FIFO of `upd_rec_t`, parameter DEPTH, with push/pop, full/empty, and async active-low reset.

## Test plan
- Reset release: count `ctr_we`=3'b111 with `ctr_clear` cycles → exactly 4096; `lht_we` in the first 1024 only; `busy` falls the following cycle; `ghr`=0.
- Single update, ip=16'h0123, taken=1, pl=0, pg=1, LHT entry 6'b000000:
  - `local_idx`={5'h03, 6'h00}, `global_idx`=12'h123, `meta_idx`=10'h123, `ctr_we`=3'b111, `ctr_inc`=3'b111, `lht_wr_data`=6'b000001.
  - `ghr`=12'h001 afterwards.
- Second update with pl==pg → `ctr_we[2]`=0; `global_idx` uses the post-first-update `ghr` (ip ^ 12'h001).
- Six back-to-back `upd_valid` cycles → `upd_ready` drops once 4 entries are pending; all 6 records are applied in order, each 2 cycles apart.
- `flush` asserted while 3 entries are pending → FIFO empty, `ghr`=0, `busy`=1, full 4096-cycle sweep, none of the 3 pending records applied.
- `rst_n` asserted mid-WRITE → outputs return to reset values asynchronously with no residual write enable.
